// File: rtl/vga_pkg.sv
// Shared VGA timing constants and frame-buffer write scheduler types.
package vga_pkg;

    localparam int unsigned H_MAX     = 1056;
    localparam int unsigned V_MAX     = 628;
    localparam int unsigned TC_W      = 11;
    localparam int unsigned FB_ADDR_W = 19;
    localparam int unsigned FB_DATA_W = 12;
    localparam int unsigned BURST_W   = 8;

    typedef enum logic [1:0] {
        WAIT_WIN = 2'd0,
        ARB      = 2'd1,
        GRANT    = 2'd2
    } sched_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bus as produced by the timing generator.
interface vga_if;
    import vga_pkg::*;

    logic [TC_W-1:0] vcount;
    logic [TC_W-1:0] hcount;
    logic            vblnk;
    logic            hblnk;
    logic            vsync;
    logic            hsync;

    modport in  (input  vcount, hcount, vblnk, hblnk, vsync, hsync);
    modport out (output vcount, hcount, vblnk, hblnk, vsync, hsync);
endinterface

// File: rtl/vga_fb_write_sched_rr_arbiter.sv
// Combinational round-robin selector: first set request at or after ptr+1.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic             valid_o
);

    int unsigned idx_c;

    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx_c   = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx_c = (32'(ptr_i) + k) % N_REQ;
            if (!valid_o && req_i[PTR_W'(idx_c)]) begin
                pick_o[PTR_W'(idx_c)] = 1'b1;
                valid_o               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_fb_write_sched.sv
// Frame-memory write scheduler: opens writes only in vertical blanking and
// grants requesters round-robin with a per-grant burst limit.
module vga_fb_write_sched
    import vga_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ADDR_W    = FB_ADDR_W,
    parameter int unsigned DATA_W    = FB_DATA_W,
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned GUARD     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    vga_if.in                        vga_in,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     win_open,
    output logic                     frame_start
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t        state_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [BURST_W-1:0]  burst_q;
    logic [BURST_W-1:0]  burst_d;
    logic                win_q;
    logic                win_d;
    logic                fs_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_data_q;
    logic [N_REQ-1:0]    pick_c;
    logic                pick_valid_c;
    logic [PTR_W-1:0]    pick_idx_c;
    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic [DATA_W-1:0]   data_arr [N_REQ];
    logic                unused_timing;

    assign unused_timing = ^{vga_in.hblnk, vga_in.vsync, vga_in.hsync};

    // Window closes GUARD pixels before the last blanking line ends.
    assign win_d = vga_in.vblnk &&
                   !((vga_in.vcount == TC_W'(V_MAX - 1)) &&
                     (vga_in.hcount >= TC_W'(H_MAX - GUARD)));

    assign burst_d = (burst_q == {BURST_W{1'b1}}) ? burst_q : burst_q + BURST_W'(1);

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick_c),
        .valid_o (pick_valid_c)
    );

    always_comb begin
        pick_idx_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_c[i]) pick_idx_c = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_WIN;
            gnt_q      <= '0;
            ptr_q      <= PTR_W'(N_REQ - 1);
            burst_q    <= '0;
            win_q      <= 1'b0;
            fs_q       <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            win_q <= win_d;
            fs_q  <= win_d & ~win_q;

            // ptr_q names the granted requester for the whole grant.
            if (|gnt_q) begin
                mem_we_q   <= req_we[ptr_q];
                mem_addr_q <= addr_arr[ptr_q];
                mem_data_q <= data_arr[ptr_q];
            end else begin
                mem_we_q <= 1'b0;
            end

            case (state_q)
                WAIT_WIN: begin
                    if (win_q) state_q <= ARB;
                end
                ARB: begin
                    if (!win_q) begin
                        state_q <= WAIT_WIN;
                    end else if (pick_valid_c) begin
                        gnt_q   <= pick_c;
                        ptr_q   <= pick_idx_c;
                        burst_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    burst_q <= burst_d;
                    if (!req[ptr_q] || !win_q || (burst_q == BURST_W'(MAX_BURST - 1))) begin
                        gnt_q   <= '0;
                        state_q <= win_q ? ARB : WAIT_WIN;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= WAIT_WIN;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign win_open    = win_q;
    assign frame_start = fs_q;

endmodule
